// File: rtl/depth_lut_scheduler_if.sv
// rtl/depth_lut_scheduler_if.sv - pixel/LUT read and output stream bundle for depth_lut_scheduler
interface depth_lut_scheduler_if #(
    parameter int LANES = 16
);
    logic                 pix_rd_en;
    logic [12:0]          pix_rd_addr;
    logic [7:0]           pix_rd_data;
    logic                 lut_rd_en;
    logic [9:0]           lut_msb_addr;
    logic [5:0]           lut_lsb_addr;
    logic [LANES*8-1:0]   lut_msb_data;
    logic [LANES*8-1:0]   lut_lsb_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [LANES*8-1:0]   out_data;
    logic [1:0]           out_c;
    logic [3:0]           out_h;
    logic [3:0]           out_w;

    modport master (
        output pix_rd_en, pix_rd_addr, lut_rd_en, lut_msb_addr, lut_lsb_addr,
               out_valid, out_data, out_c, out_h, out_w,
        input  pix_rd_data, lut_msb_data, lut_lsb_data, out_ready
    );

    modport slave (
        input  pix_rd_en, pix_rd_addr, lut_rd_en, lut_msb_addr, lut_lsb_addr,
               out_valid, out_data, out_c, out_h, out_w,
        output pix_rd_data, lut_msb_data, lut_lsb_data, out_ready
    );
endinterface

// File: rtl/depth_lut_scheduler.sv
// rtl/depth_lut_scheduler.sv - time-multiplexes one depthwise LUT engine over every 3x3 window of a tile
module depth_lut_scheduler #(
    parameter int C      = 3,
    parameter int H_IN   = 50,
    parameter int W_IN   = 50,
    parameter int STRIDE = 4,
    parameter int H_OUT  = 12,
    parameter int W_OUT  = 12,
    parameter int LANES  = 16,
    parameter int ACC_W  = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic done,
    depth_lut_scheduler_if.master bus
);
    localparam int DW = ACC_W + 1;
    localparam logic signed [DW-1:0] MSB_MAX = DW'(31);
    localparam logic signed [DW-1:0] MSB_MIN = -DW'(32);
    localparam logic signed [DW-1:0] LSB_MAX = DW'(3);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_QUANT, S_OUT} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q;
    logic [1:0]              c_q;
    logic [3:0]              h_q, w_q;
    logic                    pix_v_q, lut_v_q;
    logic [3:0]              pix_tap_q;
    logic signed [ACC_W-1:0] acc_msb_q [LANES];
    logic signed [ACC_W-1:0] acc_lsb_q [LANES];
    logic [LANES*8-1:0]      out_data_q, out_data_d;
    logic [1:0]              out_c_q;
    logic [3:0]              out_h_q, out_w_q;
    logic                    done_q;

    logic        hs, last_win;
    logic [3:0]  ky, kx;
    logic [12:0] row, col, pix_addr;

    // Round half away from zero: sign(a) * floor((|a| + 4) / 9).
    function automatic logic signed [DW-1:0] div9(input logic signed [ACC_W-1:0] a);
        logic signed [DW-1:0] ext;
        logic [DW-1:0]        mag, q;
        ext = DW'(a);
        mag = ext[DW-1] ? -ext : ext;
        q   = (mag + DW'(4)) / DW'(9);
        return ext[DW-1] ? -$signed(q) : $signed(q);
    endfunction

    function automatic logic [7:0] quant_lane(input logic signed [ACC_W-1:0] am,
                                              input logic signed [ACC_W-1:0] al);
        logic signed [DW-1:0] dm, dl;
        logic [5:0]           m6;
        logic [1:0]           l2;
        dm = div9(am);
        dl = div9(al);
        if (dm > MSB_MAX)      m6 = MSB_MAX[5:0];
        else if (dm < MSB_MIN) m6 = MSB_MIN[5:0];
        else                   m6 = dm[5:0];
        if (dl[DW-1])          l2 = 2'd0;
        else if (dl > LSB_MAX) l2 = 2'd3;
        else                   l2 = dl[1:0];
        return {m6, l2};
    endfunction

    assign hs       = (state_q == S_OUT) && bus.out_ready;
    assign last_win = (c_q == 2'(C - 1)) && (h_q == 4'(H_OUT - 1)) && (w_q == 4'(W_OUT - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (cnt_q == 4'd8) state_d = S_DRAIN;
            S_DRAIN: if (cnt_q == 4'd1) state_d = S_QUANT;
            S_QUANT: state_d = S_OUT;
            S_OUT:   if (bus.out_ready) state_d = last_win ? S_IDLE : S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // Tap index t = ky*3 + kx walks the 3x3 window anchored at (h*STRIDE, w*STRIDE).
    always_comb begin
        ky       = (cnt_q >= 4'd6) ? 4'd2 : (cnt_q >= 4'd3) ? 4'd1 : 4'd0;
        kx       = cnt_q - 4'd3 * ky;
        row      = 13'(h_q) * 13'(STRIDE) + 13'(ky);
        col      = 13'(w_q) * 13'(STRIDE) + 13'(kx);
        pix_addr = 13'(c_q) * 13'(H_IN * W_IN) + row * 13'(W_IN) + col;
    end

    always_comb begin
        out_data_d = '0;
        for (int p = 0; p < LANES; p++) begin
            out_data_d[8*p +: 8] = quant_lane(acc_msb_q[p], acc_lsb_q[p]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            c_q        <= '0;
            h_q        <= '0;
            w_q        <= '0;
            pix_v_q    <= 1'b0;
            lut_v_q    <= 1'b0;
            pix_tap_q  <= '0;
            out_data_q <= '0;
            out_c_q    <= '0;
            out_h_q    <= '0;
            out_w_q    <= '0;
            done_q     <= 1'b0;
            for (int p = 0; p < LANES; p++) begin
                acc_msb_q[p] <= '0;
                acc_lsb_q[p] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (state_d != state_q)
                cnt_q <= '0;
            else if (state_q == S_RUN || state_q == S_DRAIN)
                cnt_q <= cnt_q + 4'd1;

            // Two-stage pipeline: pixel read, then LUT read, then accumulate.
            pix_v_q   <= (state_q == S_RUN);
            pix_tap_q <= cnt_q;
            lut_v_q   <= pix_v_q;
            done_q    <= hs && last_win;

            if ((state_q == S_IDLE && start) || hs) begin
                for (int p = 0; p < LANES; p++) begin
                    acc_msb_q[p] <= '0;
                    acc_lsb_q[p] <= '0;
                end
            end else if (lut_v_q) begin
                for (int p = 0; p < LANES; p++) begin
                    acc_msb_q[p] <= acc_msb_q[p] + ACC_W'($signed(bus.lut_msb_data[8*p +: 8]));
                    acc_lsb_q[p] <= acc_lsb_q[p] + ACC_W'($signed(bus.lut_lsb_data[8*p +: 8]));
                end
            end

            if (state_q == S_IDLE && start) begin
                c_q <= '0;
                h_q <= '0;
                w_q <= '0;
            end else if (hs) begin
                if (w_q == 4'(W_OUT - 1)) begin
                    w_q <= '0;
                    if (h_q == 4'(H_OUT - 1)) begin
                        h_q <= '0;
                        c_q <= (c_q == 2'(C - 1)) ? 2'd0 : c_q + 2'd1;
                    end else begin
                        h_q <= h_q + 4'd1;
                    end
                end else begin
                    w_q <= w_q + 4'd1;
                end
            end

            if (state_q == S_QUANT) begin
                out_data_q <= out_data_d;
                out_c_q    <= c_q;
                out_h_q    <= h_q;
                out_w_q    <= w_q;
            end
        end
    end

    assign busy             = (state_q != S_IDLE);
    assign done             = done_q;
    assign bus.pix_rd_en    = (state_q == S_RUN);
    assign bus.pix_rd_addr  = (state_q == S_RUN) ? pix_addr : 13'd0;
    assign bus.lut_rd_en    = pix_v_q;
    assign bus.lut_msb_addr = pix_v_q ? {pix_tap_q, bus.pix_rd_data[7:2]} : 10'd0;
    assign bus.lut_lsb_addr = pix_v_q ? {pix_tap_q, bus.pix_rd_data[1:0]} : 6'd0;
    assign bus.out_valid    = (state_q == S_OUT);
    assign bus.out_data     = out_data_q;
    assign bus.out_c        = out_c_q;
    assign bus.out_h        = out_h_q;
    assign bus.out_w        = out_w_q;
endmodule

// File: tb/tb_depth_lut_scheduler.sv
// tb/tb_depth_lut_scheduler.sv - self-checking bench for depth_lut_scheduler
module tb_depth_lut_scheduler;
    localparam int LANES = 16;
    localparam int C = 3, H_IN = 50, W_IN = 50, STRIDE = 4, H_OUT = 12, W_OUT = 12;
    localparam int NWIN = C * H_OUT * W_OUT;

    logic clk = 1'b0;
    logic rst_n, start, busy, done;
    always #5 clk = ~clk;

    depth_lut_scheduler_if #(.LANES(LANES)) bus ();

    depth_lut_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    logic [7:0]         pix_mem     [0:C*H_IN*W_IN-1];
    logic [LANES*8-1:0] lut_msb_mem [0:1023];
    logic [LANES*8-1:0] lut_lsb_mem [0:63];

    // Synchronous SRAM models: data appears one cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.pix_rd_en) bus.pix_rd_data <= pix_mem[bus.pix_rd_addr];
        if (bus.lut_rd_en) begin
            bus.lut_msb_data <= lut_msb_mem[bus.lut_msb_addr];
            bus.lut_lsb_data <= lut_lsb_mem[bus.lut_lsb_addr];
        end
    end

    typedef struct {
        int         msb_sum;
        int         lsb_sum;
        logic [7:0] exp_byte;
    } vec_t;
    vec_t tbl [LANES];

    int n_vec = 0, n_err = 0;
    int exp_c = 0, exp_h = 0, exp_w = 0, hs_count = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int rdiv9(input int a);
        return (a < 0) ? -((-a + 4) / 9) : (a + 4) / 9;
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    function automatic logic [127:0] model(input int c, input int h, input int w);
        logic [127:0] r, wm, wl;
        logic [7:0]   px;
        byte          bm, bl;
        int           sm, sl, t, m, l;
        r = '0;
        for (int p = 0; p < LANES; p++) begin
            sm = 0;
            sl = 0;
            for (int ky = 0; ky < 3; ky++) begin
                for (int kx = 0; kx < 3; kx++) begin
                    px = pix_mem[c*H_IN*W_IN + (h*STRIDE + ky)*W_IN + w*STRIDE + kx];
                    t  = ky*3 + kx;
                    wm = lut_msb_mem[t*64 + int'(px[7:2])];
                    wl = lut_lsb_mem[t*4 + int'(px[1:0])];
                    bm = wm[8*p +: 8];
                    bl = wl[8*p +: 8];
                    sm += bm;
                    sl += bl;
                end
            end
            m = clampi(rdiv9(sm), -32, 31);
            l = clampi(rdiv9(sl), 0, 3);
            r[8*p +: 8] = {m[5:0], l[1:0]};
        end
        return r;
    endfunction

    task automatic check_output();
        chk("out_data", bus.out_data, model(exp_c, exp_h, exp_w));
        chk("out_c", 128'(bus.out_c), 128'(exp_c));
        chk("out_h", 128'(bus.out_h), 128'(exp_h));
        chk("out_w", 128'(bus.out_w), 128'(exp_w));
        hs_count++;
        if (++exp_w == W_OUT) begin
            exp_w = 0;
            if (++exp_h == H_OUT) begin
                exp_h = 0;
                if (++exp_c == C) exp_c = 0;
            end
        end
    endtask

    // Scoreboard runs on every handshake the next edge will take.
    task automatic step();
        if (!rst_n) begin
            exp_c = 0; exp_h = 0; exp_w = 0;
        end else if (bus.out_valid && bus.out_ready) begin
            check_output();
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 128'(busy), 0);
        chk({tag, "_done"}, 128'(done), 0);
        chk({tag, "_pix_en"}, 128'(bus.pix_rd_en), 0);
        chk({tag, "_pix_addr"}, 128'(bus.pix_rd_addr), 0);
        chk({tag, "_lut_en"}, 128'(bus.lut_rd_en), 0);
        chk({tag, "_msb_addr"}, 128'(bus.lut_msb_addr), 0);
        chk({tag, "_lsb_addr"}, 128'(bus.lut_lsb_addr), 0);
        chk({tag, "_valid"}, 128'(bus.out_valid), 0);
        chk({tag, "_data"}, bus.out_data, 0);
        chk({tag, "_cwh"}, 128'({bus.out_c, bus.out_h, bus.out_w}), 0);
    endtask

    task automatic clear_luts();
        for (int i = 0; i < 1024; i++) lut_msb_mem[i] = '0;
        for (int i = 0; i < 64; i++) lut_lsb_mem[i] = '0;
    endtask

    initial begin
        int first_valid, done_cyc, done_cnt, q, k, addr_hits;
        logic [127:0] first_data, pattern, snap;
        logic pend, done_seen;

        tbl[0]  = '{900, 0, 8'h7C};   tbl[1]  = '{-900, 0, 8'h80};
        tbl[2]  = '{0, 13, 8'h01};    tbl[3]  = '{0, 14, 8'h02};
        tbl[4]  = '{0, -14, 8'h00};   tbl[5]  = '{0, 40, 8'h03};
        tbl[6]  = '{4, 0, 8'h00};     tbl[7]  = '{5, 0, 8'h04};
        tbl[8]  = '{-5, 0, 8'hFC};    tbl[9]  = '{-4, 0, 8'h00};
        tbl[10] = '{279, 0, 8'h7C};   tbl[11] = '{293, 0, 8'h7C};
        tbl[12] = '{-283, 0, 8'h84};  tbl[13] = '{45, 27, 8'h17};
        tbl[14] = '{-45, 22, 8'hEE};  tbl[15] = '{100, 5, 8'h2D};

        rst_n = 1'b0;
        start = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("rst");
        rst_n = 1'b1;

        // Identity-style tile: pixels 0, lane p of every tap*64 entry holds p.
        for (int i = 0; i < C*H_IN*W_IN; i++) pix_mem[i] = 8'h00;
        clear_luts();
        pattern = '0;
        for (int t = 0; t < 9; t++)
            for (int p = 0; p < LANES; p++) lut_msb_mem[t*64][8*p +: 8] = 8'(p);
        for (int p = 0; p < LANES; p++) pattern[8*p +: 8] = 8'(p << 2);

        bus.out_ready = 1'b1;
        hs_count = 0;
        first_valid = 0; done_cyc = 0; done_cnt = 0; first_data = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", 128'(busy), 1);
        for (int n = 1; n < 6000; n++) begin
            if (done_cnt > 0 && n > done_cyc + 3) break;
            if (bus.out_valid && first_valid == 0) begin
                first_valid = n;
                first_data  = bus.out_data;
            end
            if (done) begin
                done_cnt++;
                done_cyc = n;
                chk("busy_at_done", 128'(busy), 0);
            end
            start = (n == 20 || n == 26 || n == 39);
            step();
        end
        start = 1'b0;
        chk("first_valid_cycle", 128'(first_valid), 13);
        chk("first_data_pattern", first_data, pattern);
        chk("done_cycle", 128'(done_cyc), 5617);
        chk("done_pulses", 128'(done_cnt), 1);
        chk("handshakes", 128'(hs_count), NWIN);
        chk("busy_after_done", 128'(busy), 0);

        // Rounding and clamping table: lane p gets per-lane sums from record p.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        hs_count = 0;
        clear_luts();
        for (int p = 0; p < LANES; p++) begin
            for (int t = 0; t < 9; t++) begin
                q = tbl[p].msb_sum / 9;
                lut_msb_mem[t*64][8*p +: 8] = 8'((t == 0) ? tbl[p].msb_sum - 8*q : q);
                q = tbl[p].lsb_sum / 9;
                lut_lsb_mem[t*4][8*p +: 8] = 8'((t == 0) ? tbl[p].lsb_sum - 8*q : q);
            end
        end
        bus.out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (k = 0; k < 40 && !bus.out_valid; k++) step();
        chk("tbl_valid", 128'(bus.out_valid), 1);
        for (int p = 0; p < LANES; p++)
            chk($sformatf("tbl_lane%0d", p), 128'(bus.out_data[8*p +: 8]), 128'(tbl[p].exp_byte));

        snap = bus.out_data;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", 128'(bus.out_valid), 1);
            chk("bp_data", bus.out_data, snap);
            chk("bp_cwh", 128'({bus.out_c, bus.out_h, bus.out_w}), 0);
            chk("bp_no_reads", 128'({bus.pix_rd_en, bus.lut_rd_en}), 0);
        end
        bus.out_ready = 1'b1;
        step();
        chk("bp_release_pix_en", 128'(bus.pix_rd_en), 1);
        chk("bp_release_addr", 128'(bus.pix_rd_addr), 4);
        for (k = 0; k < 40 && !bus.out_valid; k++) step();
        chk("bp_next_out_w", 128'(bus.out_w), 1);
        step();

        // Random tile with a reset abandoned mid-RUN in window 5.
        for (int i = 0; i < C*H_IN*W_IN; i++) pix_mem[i] = 8'($urandom);
        pix_mem[3013] = 8'hB6;
        for (int i = 0; i < 1024; i++)
            for (int j = 0; j < 4; j++) lut_msb_mem[i][32*j +: 32] = $urandom;
        for (int i = 0; i < 64; i++)
            for (int j = 0; j < 4; j++) lut_lsb_mem[i][32*j +: 32] = $urandom;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        hs_count = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (k = 0; k < 500 && hs_count < 5; k++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        for (k = 0; k < 40 && !bus.pix_rd_en; k++) step();
        step();
        step();
        chk("mid_run_reads", 128'(bus.pix_rd_en), 1);
        #1 rst_n = 1'b0;
        #1 check_zero("async_rst");
        @(negedge clk);
        step();
        rst_n = 1'b1;
        hs_count = 0;

        start = 1'b1;
        step();
        start = 1'b0;
        addr_hits = 0; pend = 1'b0; done_seen = 1'b0;
        for (k = 0; k < 20000; k++) begin
            if (pend) begin
                chk("addr_lut_en", 128'(bus.lut_rd_en), 1);
                chk("addr_msb", 128'(bus.lut_msb_addr), 493);
                chk("addr_lsb", 128'(bus.lut_lsb_addr), 30);
                pend = 1'b0;
            end
            if (bus.pix_rd_en && bus.pix_rd_addr == 13'd3013) begin
                addr_hits++;
                pend = 1'b1;
            end
            if (done) begin
                done_seen = 1'b1;
                break;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        chk("rand_done_seen", 128'(done_seen), 1);
        chk("rand_handshakes", 128'(hs_count), NWIN);
        chk("addr_3013_hits", 128'(addr_hits), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/depth_lut_scheduler.md
Name: depth_lut_scheduler

Overview:
- Sequential controller that time-multiplexes one depthwise interpolation LUT lookup engine over every 3x3 input window of a C x H_IN x W_IN tile.
- Generates pixel-buffer and LUT read addresses and accumulates LANES upsample lanes for MSB and LSB planes.
- Applies rounding divide-by-9 and clamping, then emits one packed output vector per window over a valid/ready stream.
- Sits between the input tile SRAM / LUT SRAMs and the output writer.

Parameters:
- C, 3, channels
- H_IN, 50, input rows
- W_IN, 50, input columns
- STRIDE, 4, window step (upscale factor)
- H_OUT, 12, windows per column
- W_OUT, 12, windows per row
- LANES, 16, upsample points per window (STRIDE*STRIDE)
- ACC_W, 16, signed accumulator width per lane

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle start pulse; honoured only in IDLE
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse after the last output handshake
- pix_rd_en  out  1  pixel read strobe
- pix_rd_addr  out  13  flattened address c*H_IN*W_IN + row*W_IN + col
- pix_rd_data  in  8  signed pixel, valid exactly 1 cycle after pix_rd_en
- lut_rd_en  out  1  LUT read strobe
- lut_msb_addr  out  10  tap*64 + pixel[7:2]
- lut_lsb_addr  out  6  tap*4 + pixel[1:0]
- lut_msb_data  in  LANES*8  signed 8-bit per lane, lane p at [8p+7:8p], valid 1 cycle after lut_rd_en
- lut_lsb_data  in  LANES*8  same layout
- out_valid  out  1  output vector valid
- out_ready  in  1  downstream accept
- out_data  out  LANES*8  lane p = {msb6, lsb2}
- out_c  out  2  channel of out_data
- out_h  out  4  window row of out_data
- out_w  out  4  window column of out_data

Behaviour:
- Reset:
  - async, rst_n low forces state IDLE and zeroes all counters and accumulators.
  - All outputs read 0, including out_data, addresses and strobes.
  - Reset mid-operation abandons the tile; the next start begins at window (0,0,0).
- Window order: c outer, then h, then w innermost. Window origin is (h*STRIDE, w*STRIDE).
- Tap order: tap = ky*3 + kx, taps 0..8. Tap pixel is at row h*STRIDE+ky, col w*STRIDE+kx.
- FSM states and transitions:
  - IDLE: start moves to RUN; accumulators cleared.
  - RUN: 9 cycles. Cycle t asserts pix_rd_en with tap t's address.
  - Pipeline: the cycle after each pixel read, assert lut_rd_en with addresses from pix_rd_data. The cycle after each LUT read, add sign-extended lut data to the per-lane acc_msb / acc_lsb.
  - DRAIN: 2 cycles that finish the last LUT read and accumulate.
  - QUANT: 1 cycle.
    - div = round-half-away-from-zero(acc/9), i.e. sign(acc)*floor((|acc|+4)/9).
    - msb = clamp(div_msb, -32, 31).
    - lsb = clamp(div_lsb, 0, 3).
    - Registers out_data and out_c/h/w.
  - OUT: out_valid=1; out_data and indices held stable until out_ready.
    - On handshake, clear accumulators and advance indices.
    - Go to RUN, or to IDLE with done=1 for 1 cycle if this was window (C-1, H_OUT-1, W_OUT-1).
- No overlap between windows: no pixel or LUT reads are issued during QUANT or OUT.
- With out_ready held high, each window takes 13 cycles.
  - Start sampled at edge 0 gives first out_valid in cycle 13.
  - Full tile: C*H_OUT*W_OUT*13 = 5616 cycles, then done in the next cycle.
- start while busy is ignored; busy is low in the done cycle.
- out_valid is never dropped without a handshake; out_ready while out_valid is low has no effect.

Test Plan:
- All pixels 0; LUT_MSB entry tap*64 = p in lane p for all taps; LUT_LSB all 0; out_ready=1 -> every window gives lane p = p<<2; first out_valid in cycle 13; done in cycle 5617; busy low from then.
- LSB rounding: LUT_LSB sums per lane of 13, 14, -14, 40 -> lsb fields 1, 2, 0, 3. MSB clamp: per-lane sums 900 and -900 -> bytes 0x7C and 0x80.
- Address check: window (c=1,h=2,w=3), tap 7 (ky=2,kx=1) -> pix_rd_addr 3013. Pixel 0xB6 -> lut_msb_addr 7*64+45 = 493, lut_lsb_addr 7*4+2 = 30.
- Backpressure: hold out_ready low 5 cycles at the first output -> out_valid, out_data and out_c/h/w stable, no pix_rd_en/lut_rd_en; on release, next RUN starts the following cycle with out_w=1.
- Reset mid-RUN in window 5 -> all outputs 0 immediately. A new start produces out_c=out_h=out_w=0 first with freshly cleared accumulators (result matches the no-reset run).
- Pulse start during RUN and during OUT -> no effect: exactly 432 handshakes and one done pulse.
